// File: rtl/ifq_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package ifq_pkg;

  localparam int unsigned IFQ_DEPTH     = 4;
  localparam int unsigned IFQ_MAX_OUTST = 2;
  localparam logic [31:0] IFQ_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] PC_STEP       = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        illegal;
  } ifq_entry_t;

  // Anything whose low two bits are not 2'b11 is a 16-bit or reserved encoding.
  function automatic logic is_not_rv32(input logic [31:0] word);
    return word[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO of fetched entries with clear; flag storage only when
// IFQ_ILLEGAL_CHK_EN is defined.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH = IFQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  ifq_entry_t             push_data_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  output ifq_entry_t             head_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign do_push = push_i && !clear_i;
  assign do_pop  = pop_i && !empty_o && !clear_i;

  // NOTE: every signal gets its default first so always_comb cannot infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: non-blocking assignments make all registers sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef IFQ_ILLEGAL_CHK_EN
  ifq_entry_t mem_q [DEPTH];

  // NOTE: the storage array is not reset; count and pointers alone define which slots are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o = mem_q[rd_ptr_q];
`else
  logic [63:0] mem_q [DEPTH];
  logic        unused_illegal;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {push_data_i.pc, push_data_i.inst};
  end

  assign unused_illegal = push_data_i.illegal;
  assign head_o.pc      = mem_q[rd_ptr_q][63:32];
  assign head_o.inst    = mem_q[rd_ptr_q][31:0];
  assign head_o.illegal = 1'b0;
`endif

  // Space is reserved at issue time, so a push into a full FIFO is a protocol error.
  overflow_a : assert property (@(posedge clk) disable iff (!rst_n)
    !(do_push && full_o && !do_pop));

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: sequential IM requests, in-flight tracking,
// redirect flush. Define IFQ_ILLEGAL_CHK_EN to flag non-32-bit encodings.
module inst_fetch_queue
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH     = IFQ_DEPTH,
  parameter int unsigned MAX_OUTST = IFQ_MAX_OUTST,
  parameter logic [31:0] RESET_PC  = IFQ_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        im_req_valid_o,
  output logic [31:0] im_req_addr_o,
  input  logic        im_req_ready_i,
  input  logic        im_resp_valid_i,
  input  logic [31:0] im_resp_data_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_out_valid_o,
  output logic [31:0] if_out_inst_o,
  output logic [31:0] if_out_pc_o,
  output logic        if_out_illegal_o,
  input  logic        id_in_ready_i
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_L = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] MAX_L   = CW'(MAX_OUTST);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] kill_q, kill_d;
  logic          started_q;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_full;
  ifq_entry_t    head, push_entry;
  logic          has_space, req_fire, resp_drop, push, pop;
  logic [31:0]   redirect_pc_aligned;
  logic          unused_fifo_full;

  assign redirect_pc_aligned = redirect_pc_i & ~32'h3;
  assign has_space = ({1'b0, fifo_count} + {1'b0, outst_q}) < DEPTH_L;

  // started_q keeps requests off until the first cycle after reset release.
  assign im_req_valid_o = started_q && !redirect_valid_i && has_space && (outst_q < MAX_L);
  assign im_req_addr_o  = fetch_pc_q;
  assign req_fire       = im_req_valid_o && im_req_ready_i;

  assign resp_drop = (kill_q != '0);
  assign push      = im_resp_valid_i && !resp_drop && !redirect_valid_i;
  assign pop       = if_out_valid_o && id_in_ready_i;

  assign push_entry.pc   = resp_pc_q;
  assign push_entry.inst = im_resp_data_i;
`ifdef IFQ_ILLEGAL_CHK_EN
  assign push_entry.illegal = is_not_rv32(im_resp_data_i);
`else
  assign push_entry.illegal = 1'b0;
`endif

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    kill_d     = kill_q;

    if (req_fire && !im_resp_valid_i) begin
      outst_d = outst_q + CW'(1);
    end else if (!req_fire && im_resp_valid_i && outst_q != '0) begin
      outst_d = outst_q - CW'(1);
    end

    if (redirect_valid_i) begin
      // A response landing in the redirect cycle is itself dropped, so it leaves the kill count.
      kill_d     = (im_resp_valid_i && outst_q != '0) ? outst_q - CW'(1) : outst_q;
      fetch_pc_d = redirect_pc_aligned;
      resp_pc_d  = redirect_pc_aligned;
    end else begin
      if (im_resp_valid_i && resp_drop) kill_d     = kill_q - CW'(1);
      if (req_fire)                     fetch_pc_d = fetch_pc_q + PC_STEP;
      if (push)                         resp_pc_d  = resp_pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      kill_q     <= '0;
      started_q  <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      kill_q     <= kill_d;
      started_q  <= 1'b1;
    end
  end

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .clear_i     (redirect_valid_i),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (fifo_count)
  );

  assign unused_fifo_full = fifo_full;

  // Head fields are zeroed when empty so decode never sees stale storage.
  assign if_out_valid_o = !fifo_empty;
  assign if_out_inst_o  = fifo_empty ? 32'h0 : head.inst;
  assign if_out_pc_o    = fifo_empty ? 32'h0 : head.pc;
`ifdef IFQ_ILLEGAL_CHK_EN
  assign if_out_illegal_o = !fifo_empty && head.illegal;
`else
  logic unused_head_illegal;
  assign unused_head_illegal = head.illegal;
  assign if_out_illegal_o    = 1'b0;
`endif

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction-fetch front end that produces the 32-bit instruction word consumed by the decode stage.
- Generates sequential fetch addresses to instruction memory and tracks in-flight requests.
- Buffers returned words with their PC in a small FIFO and presents them to decode through a valid/ready handshake.
- On a branch/jump redirect from execute, flushes the queue and discards stale responses.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- MAX_OUTST, 2, maximum in-flight IM requests; at most DEPTH.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- im_req_valid  out  1  fetch request valid.
- im_req_addr  out  32  fetch byte address, always word-aligned.
- im_req_ready  in  1  IM accepts the request this cycle.
- im_resp_valid  in  1  returned word valid; responses arrive in request order.
- im_resp_data  in  32  returned instruction word.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch PC; bits [1:0] are ignored and forced to 0.
- if_out_valid  out  1  head entry valid toward decode.
- if_out_inst  out  32  head instruction word.
- if_out_pc  out  32  head PC.
- if_out_illegal  out  1  head word is not a 32-bit encoding (see Optional Feature).
- id_in_ready  in  1  decode consumes the head this cycle.

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc = RESET_PC; FIFO empty; outst = 0; kill = 0.
  - All outputs 0.
  - im_req_valid is first asserted in the cycle after reset release.
- Request issue: im_req_valid = !redirect_valid && (count + outst < DEPTH) && (outst < MAX_OUTST).
  - im_req_addr = fetch_pc.
  - A handshake (valid && ready) increments fetch_pc by 4, wrapping modulo 2^32 with no flag.
- Outstanding counter: outst increments on request handshake and decrements on im_resp_valid. Both in the same cycle leave it unchanged.
- Response handling:
  - If kill > 0: the response is dropped and kill decrements.
  - Otherwise the word is pushed with its PC, taken from a resp_pc register that increments by 4 per accepted response.
  - Push never overflows because space is reserved at issue time. An overflow is a protocol error and must trigger an assertion.
- Decode side:
  - if_out_valid = !empty.
  - if_out_inst, if_out_pc and if_out_illegal are driven combinationally from the FIFO head.
  - Pop when if_out_valid && id_in_ready.
  - Push and pop in the same cycle: count is unchanged. With an empty FIFO, a push is not bypassed; the word is visible the next cycle, giving 2-cycle latency from IM handshake to if_out_valid with 1-cycle memory.
- Redirect (takes priority over everything in the same cycle):
  - FIFO cleared, so if_out_valid = 0 next cycle; any pop in that cycle is ignored.
  - kill = outst minus 1 if a response arrives in the same cycle (that response is also dropped), otherwise kill = outst.
  - fetch_pc = resp_pc = redirect_pc & ~3.
  - im_req_valid is held 0 during the redirect cycle.
  - Back-to-back redirects: each recomputes kill from the current outst.
- Reset mid-operation: all state cleared immediately. IM must also be reset, so no responses arrive after reset.

Optional Feature:
- Macro: IFQ_ILLEGAL_CHK_EN.
- Defined: each entry stores a flag set when word[1:0] != 2'b11 (compressed or invalid encoding). if_out_illegal reflects the head entry's flag.
- Undefined: no flag storage; if_out_illegal is tied to 0.

Decomposition:
- Package ifq_pkg:
  - Typedef ifq_entry_t {pc[31:0], inst[31:0], illegal}.
  - Constants: default DEPTH, MAX_OUTST, RESET_PC, and PC_STEP = 4.
- Sub-module ifq_fifo: synchronous FIFO of ifq_entry_t with push, pop, clear, empty, full and count outputs.
- Parent inst_fetch_queue owns fetch_pc, resp_pc, outst and kill.

Test Plan:
- Reset release, im_req_ready = 1, 1-cycle memory returning addr^32'hA5A5_0000, id_in_ready = 1:
  - requests 0x0, 0x4, 0x8, … in consecutive cycles;
  - if_out_pc 0x0 appears 2 cycles after the first handshake with inst 32'hA5A5_0000.
- id_in_ready = 0 with DEPTH = 4:
  - exactly 4 requests issue, then im_req_valid stays 0;
  - raising id_in_ready pops entries in order 0x0..0xC and fetching resumes at 0x10.
- Redirect to 0x0000_1003 with 2 requests outstanding:
  - FIFO empty next cycle; the next 2 responses are dropped;
  - the next request address is 0x1000 and the first delivered pc is 0x1000.
- Redirect in the same cycle as a response and a decode pop:
  - that response is not pushed, the pop has no effect, and kill = outst - 1.
- fetch_pc = 0xFFFF_FFFC: the next request after 0xFFFF_FFFC is 0x0000_0000, with no stall.
- With IFQ_ILLEGAL_CHK_EN defined, response 32'h0000_4501: if_out_illegal = 1. With 32'h0000_0013: if_out_illegal = 0.
